fetch_ctrl: RTL

Instruction-fetch controller and memory-side responder for the PC unit. It takes the current PC and issues a read to a multi-cycle instruction memory. It waits for completion, then hands the instruction word and its PC to decode through a valid/stall handshake. It drives the PC unit's stall input so the PC advances only when a fetch is accepted, and it drains in-flight reads cleanly on a branch/jump redirect.

---
 rtl/fetch_pkg.sv | 16 +
 rtl/fetch_hold_buf.sv | 54 +++++
 rtl/fetch_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared state encoding and default widths for the fetch controller
package fetch_pkg;

    localparam int          FETCH_ADDR_W    = 16;
    localparam int          FETCH_DATA_W    = 16;
    localparam logic [15:0] FETCH_NOP_INSTR = 16'h0800;

    typedef enum logic [2:0] {
        ST_REQ    = 3'd0,
        ST_WAIT   = 3'd1,
        ST_DRAIN  = 3'd2,
        ST_HOLD   = 3'd3,
        ST_HALTED = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/fetch_hold_buf.sv
// rtl/fetch_hold_buf.sv - one-entry instruction word + pc buffer used while decode stalls
module fetch_hold_buf
    import fetch_pkg::*;
#(
    parameter int ADDR_W = FETCH_ADDR_W,
    parameter int DATA_W = FETCH_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              clear,
    input  logic [DATA_W-1:0] data_in,
    input  logic [ADDR_W-1:0] pc_in,
    output logic [DATA_W-1:0] data_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic              valid
);

    logic [DATA_W-1:0] data_q, data_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              valid_q, valid_d;

    // Clear wins over load so a redirect always empties the buffer
    always_comb begin
        data_d  = data_q;
        pc_d    = pc_q;
        valid_d = valid_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (load) begin
            data_d  = data_in;
            pc_d    = pc_in;
            valid_d = 1'b1;
        end
    end

    // Buffer storage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q  <= '0;
            pc_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            pc_q    <= pc_d;
            valid_q <= valid_d;
        end
    end

    assign data_out = data_q;
    assign pc_out   = pc_q;
    assign valid    = valid_q;

endmodule

// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch controller (optional perf counters: FETCH_PERF_EN)
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int                ADDR_W    = FETCH_ADDR_W,
    parameter int                DATA_W    = FETCH_DATA_W,
    parameter logic [DATA_W-1:0] NOP_INSTR = DATA_W'(FETCH_NOP_INSTR)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_addr,
    input  logic              flush,
    input  logic              halt,
    input  logic              dec_stall,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              mem_done,
    input  logic              mem_stall,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    output logic              pc_stall,
    output logic              err,
    output logic [15:0]       perf_fetch_cnt,
    output logic [15:0]       perf_stall_cnt
);

    fetch_state_t      state_q, state_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic              instr_valid_q, instr_valid_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic              err_q, err_d;

    logic              mem_rd_c;
    logic              taken;
    logic              pc_stall_c;
    logic              deliver;
    logic              hb_load, hb_clear, hb_valid;
    logic [DATA_W-1:0] hb_data;
    logic [ADDR_W-1:0] hb_pc;

    fetch_hold_buf #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_hold_buf (
        .clk      (clk),
        .rst      (rst),
        .load     (hb_load),
        .clear    (hb_clear),
        .data_in  (mem_data),
        .pc_in    (req_pc_q),
        .data_out (hb_data),
        .pc_out   (hb_pc),
        .valid    (hb_valid)
    );

    // Request issue: only from REQ, and only when decode can take the result and no halt is pending
    always_comb begin
        mem_rd_c = rst && (state_q == ST_REQ) && !dec_stall && !halt;
        taken    = mem_rd_c && !mem_stall;
    end

    // Next-state, output-register and PC-stall decisions; redirect dominates except when halted
    always_comb begin
        state_d       = state_q;
        instr_d       = instr_q;
        instr_pc_d    = instr_pc_q;
        instr_valid_d = instr_valid_q;
        req_pc_d      = mem_rd_c ? pc_addr : req_pc_q;
        err_d         = err_q;
        hb_load       = 1'b0;
        hb_clear      = 1'b0;
        pc_stall_c    = 1'b1;
        deliver       = 1'b0;

        // Completion for a read we never asked for, or while we cannot accept one
        if (mem_done && ((state_q == ST_HOLD) || (state_q == ST_HALTED) ||
                         ((state_q == ST_REQ) && !mem_rd_c))) begin
            err_d = 1'b1;
        end

        if (flush && (state_q != ST_HALTED)) begin
            pc_stall_c    = 1'b0;
            instr_valid_d = 1'b0;
            instr_d       = NOP_INSTR;
            hb_clear      = 1'b1;
            case (state_q)
                ST_REQ:   state_d = (taken && !mem_done) ? ST_DRAIN : ST_REQ;
                ST_WAIT:  state_d = mem_done ? ST_REQ : ST_DRAIN;
                ST_DRAIN: state_d = mem_done ? ST_REQ : ST_DRAIN;
                ST_HOLD:  state_d = ST_REQ;
                default:  state_d = state_q;
            endcase
        end else begin
            // Decode consumed whatever it had; show NOP unless something new lands below
            if (!dec_stall) begin
                instr_valid_d = 1'b0;
                instr_d       = NOP_INSTR;
            end
            case (state_q)
                ST_REQ: begin
                    if (taken) begin
                        if (mem_done) begin
                            pc_stall_c    = 1'b0;
                            instr_d       = mem_data;
                            instr_pc_d    = pc_addr;
                            instr_valid_d = 1'b1;
                            deliver       = 1'b1;
                        end else begin
                            state_d = ST_WAIT;
                        end
                    end else if (halt) begin
                        state_d = ST_HALTED;
                    end
                end
                ST_WAIT: begin
                    if (mem_done) begin
                        pc_stall_c = 1'b0;
                        if (!dec_stall) begin
                            instr_d       = mem_data;
                            instr_pc_d    = req_pc_q;
                            instr_valid_d = 1'b1;
                            deliver       = 1'b1;
                            state_d       = halt ? ST_HALTED : ST_REQ;
                        end else begin
                            hb_load = 1'b1;
                            state_d = ST_HOLD;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (mem_done) begin
                        state_d = ST_REQ;
                    end
                end
                ST_HOLD: begin
                    if (!dec_stall) begin
                        instr_d       = hb_data;
                        instr_pc_d    = hb_pc;
                        instr_valid_d = hb_valid;
                        deliver       = hb_valid;
                        hb_clear      = 1'b1;
                        state_d       = halt ? ST_HALTED : ST_REQ;
                    end
                end
                ST_HALTED: begin
                    instr_valid_d = 1'b0;
                    instr_d       = NOP_INSTR;
                end
                default: state_d = ST_REQ;
            endcase
        end
    end

    // Controller state and registered decode-side outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_REQ;
            instr_q       <= NOP_INSTR;
            instr_pc_q    <= '0;
            instr_valid_q <= 1'b0;
            req_pc_q      <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            instr_q       <= instr_d;
            instr_pc_q    <= instr_pc_d;
            instr_valid_q <= instr_valid_d;
            req_pc_q      <= req_pc_d;
            err_q         <= err_d;
        end
    end

    assign mem_rd      = mem_rd_c;
    assign mem_addr    = mem_rd_c ? pc_addr : req_pc_q;
    assign pc_stall    = !rst || pc_stall_c;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_valid = instr_valid_q;
    assign err         = err_q;

`ifdef FETCH_PERF_EN
    logic [15:0] perf_fetch_q, perf_fetch_d;
    logic [15:0] perf_stall_q, perf_stall_d;
    logic        stall_cnt_en;

    // Wrapping event counters: delivered instructions and non-halted PC stall cycles
    always_comb begin
        stall_cnt_en = pc_stall && (state_q != ST_HALTED);
        perf_fetch_d = perf_fetch_q + {15'd0, deliver};
        perf_stall_d = perf_stall_q + {15'd0, stall_cnt_en};
    end

    // Counter storage
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetch_q <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_fetch_cnt = perf_fetch_q;
    assign perf_stall_cnt = perf_stall_q;
`else
    logic unused_deliver;
    assign unused_deliver = deliver;
    assign perf_fetch_cnt = 16'd0;
    assign perf_stall_cnt = 16'd0;
`endif

endmodule
